// File: rtl/read_module.sv
// read_module: memory-read front end for the vector ASIP datapath.
// Drives a data-memory address of base_address + idx. A scalar operation
// passes the memory word straight through. A vector operation gathers one
// element per clock into vreg and bypasses the element currently being read
// onto vector_data, so every element is visible in the cycle it is fetched.
module read_module #(
    parameter int VLEN = 20,  // highest element index; the vector holds VLEN+1 words
    parameter int DW   = 10,  // data word width
    parameter int AW   = 6    // memory address width
) (
    input  logic                   clk,
    input  logic                   rst,           // asynchronous, active-low
    input  logic                   op_type,       // 0 = scalar read, 1 = vector read
    input  logic [AW-1:0]          base_address,
    input  logic [DW-1:0]          read_data,
    output logic [AW-1:0]          read_address,
    output logic [DW-1:0]          scalar_data,
    output logic [VLEN:0][DW-1:0]  vector_data
);

    // The index needs at least one bit even for a single-element vector.
    localparam int IW = (VLEN > 0) ? $clog2(VLEN + 1) : 1;
    // The address sum is formed at the wider of the two widths, then cut
    // back to AW bits so it wraps modulo 2^AW.
    localparam int SW = (AW > IW) ? AW : IW;
    localparam logic [IW-1:0] IDX_LAST = IW'(VLEN);

    logic [IW-1:0]          idx;
    logic [VLEN:0][DW-1:0]  vreg;
    logic [DW-1:0]          sreg;
    logic [SW-1:0]          addr_sum;

    assign addr_sum     = SW'(base_address) + SW'(idx);
    assign read_address = addr_sum[AW-1:0];

    // Scalar reads are combinational; vector mode shows the last captured scalar.
    assign scalar_data = op_type ? sreg : read_data;

    // Element view: the element under fetch is bypassed, the rest come from vreg.
    always_comb begin
        // NOTE: assigning a full default before the per-element override keeps
        // every bit driven on every path, so no latch can be inferred.
        vector_data = vreg;
        for (int k = 0; k <= VLEN; k++) begin
            if (op_type && (idx == IW'(k))) begin
                vector_data[k] = read_data;
            end
        end
    end

    // Element index: counts through 0..VLEN in vector mode, wraps, and is
    // parked at 0 by any scalar cycle so the next vector starts at element 0.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            idx <= '0;
        end else if (!op_type) begin
            idx <= '0;
        end else if (idx == IDX_LAST) begin
            idx <= '0;
        end else begin
            idx <= idx + IW'(1);
        end
    end

    // Scalar hold register: captures the memory word on every scalar cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
        end else if (!op_type) begin
            sreg <= read_data;
        end
    end

    // Element registers: the word fetched for element idx is stored at the
    // closing edge of its cycle; contents survive scalar cycles.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: this register array is reset on purpose -- its contents are
        // architecturally visible on vector_data, and reset must show zeros.
        if (!rst) begin
            vreg <= '0;
        end else if (op_type) begin
            for (int k = 0; k <= VLEN; k++) begin
                if (idx == IW'(k)) begin
                    vreg[k] <= read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_module.sv
// Bench for read_module: directed stimulus pushes hand-computed expectations
// into a queue; a monitor pops and compares them at the falling clock edge.
module tb_read_module;

    localparam int VLEN = 20;
    localparam int DW   = 10;
    localparam int AW   = 6;

    typedef logic [VLEN:0][DW-1:0] vec_t;

    typedef struct {
        string          name;
        bit             chk_addr;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  sdata;
        vec_t           vdata;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic                  op_type;
    logic [AW-1:0]         base_address;
    logic [DW-1:0]         read_data;
    logic [AW-1:0]         read_address;
    logic [DW-1:0]         scalar_data;
    vec_t                  vector_data;

    exp_t  exp_q[$];
    vec_t  ev;          // expected contents of vector_data for the next step
    int    checks;
    int    errors;

    read_module #(.VLEN(VLEN), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_type      (op_type),
        .base_address (base_address),
        .read_data    (read_data),
        .read_address (read_address),
        .scalar_data  (scalar_data),
        .vector_data  (vector_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every expectation queued before a falling edge is compared there.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_addr) check({e.name, " addr"}, 256'(read_address), 256'(e.addr));
                check({e.name, " scalar"}, 256'(scalar_data), 256'(e.sdata));
                check({e.name, " vector"}, 256'(vector_data), 256'(e.vdata));
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue its expectation.
    task automatic step(input logic r, input logic op, input logic [AW-1:0] base,
                        input logic [DW-1:0] rd, input bit chk_a,
                        input logic [AW-1:0] ea, input logic [DW-1:0] es,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        op_type      = op;
        base_address = base;
        read_data    = rd;
        e.name     = name;
        e.chk_addr = chk_a;
        e.addr     = ea;
        e.sdata    = es;
        e.vdata    = ev;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic [AW-1:0] wrap_addr [6];
        wrap_addr = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1};
        checks = 0;
        errors = 0;
        ev     = '0;

        // 1. Reset held, scalar pass-through.
        rst = 1'b0; op_type = 1'b0; base_address = 6'd34; read_data = 10'd900;
        e.name = "reset"; e.chk_addr = 1'b1; e.addr = 6'd34; e.sdata = 10'd900; e.vdata = '0;
        exp_q.push_back(e);
        step(1'b1, 1'b0, 6'd34, 10'd900, 1'b1, 6'd34, 10'd900, "release_scalar");
        step(1'b1, 1'b0, 6'd34, 10'd900, 1'b1, 6'd34, 10'd900, "scalar");

        // 2. Vector gather of five elements.
        for (int k = 0; k < 5; k++) begin
            ev[k] = DW'(900 + k);
            step(1'b1, 1'b1, 6'd34, DW'(900 + k), 1'b1, AW'(34 + k), 10'd900, "gather");
        end
        // Scalar cycle ends the gather; vreg stays visible.
        step(1'b1, 1'b0, 6'd34, 10'd77, 1'b0, 6'd0, 10'd77, "switch_to_scalar");

        // 3. Full vector plus wrap back to element 0.
        for (int k = 0; k <= VLEN; k++) begin
            ev[k] = DW'(100 + k);
            step(1'b1, 1'b1, 6'd34, DW'(100 + k), 1'b1, AW'(34 + k), 10'd77, "full_vector");
        end
        ev[0] = 10'd555;
        step(1'b1, 1'b1, 6'd34, 10'd555, 1'b1, 6'd34, 10'd77, "vector_wrap");

        // Two scalar cycles: the second must address base_address.
        step(1'b1, 1'b0, 6'd34, 10'd88, 1'b0, 6'd0, 10'd88, "scalar_after_wrap");
        step(1'b1, 1'b0, 6'd34, 10'd89, 1'b1, 6'd34, 10'd89, "scalar_base");

        // 5. Mode switch after three vector cycles.
        for (int k = 0; k < 3; k++) begin
            ev[k] = DW'(300 + k);
            step(1'b1, 1'b1, 6'd34, DW'(300 + k), 1'b1, AW'(34 + k), 10'd89, "pre_switch");
        end
        step(1'b1, 1'b0, 6'd34, 10'd55, 1'b0, 6'd0, 10'd55, "mid_switch");
        ev[0] = 10'd400;
        step(1'b1, 1'b1, 6'd34, 10'd400, 1'b1, 6'd34, 10'd55, "restart_elem0");
        ev[1] = 10'd401;
        step(1'b1, 1'b1, 6'd34, 10'd401, 1'b1, 6'd35, 10'd55, "restart_elem1");

        // 4. Address wrap modulo 64, then base change mid-vector.
        step(1'b1, 1'b0, 6'd60, 10'd1, 1'b0, 6'd0, 10'd1, "scalar_before_wrap");
        for (int k = 0; k < 6; k++) begin
            ev[k] = DW'(500 + k);
            step(1'b1, 1'b1, 6'd60, DW'(500 + k), 1'b1, wrap_addr[k], 10'd1, "addr_wrap");
        end
        ev[6] = 10'd506;
        step(1'b1, 1'b1, 6'd10, 10'd506, 1'b1, 6'd16, 10'd1, "base_change");

        // 6. Asynchronous reset asserted between edges mid-vector.
        ev = '0;
        step(1'b0, 1'b1, 6'd10, 10'd0, 1'b1, 6'd10, 10'd0, "async_reset_vec");
        step(1'b0, 1'b0, 6'd10, 10'd77, 1'b1, 6'd10, 10'd77, "async_reset_scalar");
        ev[0] = 10'd600;
        step(1'b1, 1'b1, 6'd10, 10'd600, 1'b1, 6'd10, 10'd0, "post_reset_elem0");
        ev[1] = 10'd601;
        step(1'b1, 1'b1, 6'd10, 10'd601, 1'b1, 6'd11, 10'd0, "post_reset_elem1");

        // Let the monitor drain the queue, within a bounded wait.
        for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
